// File: rtl/config_frame_loader.sv
// Configuration frame loader: syncs on a 32-bit word stream, assembles one frame per
// column and drives frame data plus a one-hot latch strobe. Optional checksum word: CFG_CHECKSUM_EN.
module config_frame_loader #(
    parameter int          NUM_ROWS      = 4,
    parameter int          MAX_FRAMES    = 20,
    parameter int          COL_ADDR_W    = 5,
    parameter int          STROBE_CYCLES = 2,
    parameter logic [31:0] SYNC_WORD     = 32'hFAB0_FAB1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [31:0]            WriteData,
    input  logic                   WriteStrobe,
    output logic                   WriteReady,
    output logic [32*NUM_ROWS-1:0] FrameData,
    output logic [COL_ADDR_W-1:0]  FrameAddress,
    output logic [MAX_FRAMES-1:0]  FrameStrobe,
    output logic                   Synced,
    output logic                   Error
);
    localparam int FD_W   = 32 * NUM_ROWS;
    localparam int CNT_W  = $clog2(NUM_ROWS + 1);
    localparam int SCNT_W = $clog2(STROBE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LAST_WORD   = CNT_W'(NUM_ROWS - 1);
    localparam logic [SCNT_W-1:0] LAST_STROBE = SCNT_W'(STROBE_CYCLES - 1);
    localparam logic [5:0]        FRAME_LIMIT = 6'(MAX_FRAMES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_DATA,
`ifdef CFG_CHECKSUM_EN
        S_CHECK,
`endif
        S_STROBE,
        S_HOLD
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        word_cnt_reg, word_cnt_next;
    logic [SCNT_W-1:0]       strobe_cnt_reg, strobe_cnt_next;
    logic [COL_ADDR_W-1:0]   col_reg, col_next;
    logic [4:0]              idx_reg, idx_next;
    logic                    synced_reg, synced_next;
    logic                    error_reg, error_next;
    logic [FD_W-1:0]         frame_data_reg;
    logic [COL_ADDR_W-1:0]   frame_addr_reg;
    logic [MAX_FRAMES-1:0]   strobe_reg;
    logic [31:0]             staging_reg [NUM_ROWS];
    logic [FD_W-1:0]         staging_flat;
    logic [FD_W-1:0]         frame_src;
    logic [MAX_FRAMES-1:0]   strobe_decode;
    logic                    accept, is_sync, idx_valid;
    logic                    staging_we, frame_done, frame_ok, load_frame;
`ifdef CFG_CHECKSUM_EN
    logic [31:0]             checksum_reg, checksum_next;
`endif

    assign accept     = WriteStrobe && WriteReady;
    assign is_sync    = (WriteData == SYNC_WORD);
    assign idx_valid  = ({1'b0, idx_reg} < FRAME_LIMIT);
    assign WriteReady = !((state_reg == S_STROBE) || (state_reg == S_HOLD));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ROWS; gi++) begin : g_row
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    staging_reg[gi] <= '0;
                end else if (staging_we && (word_cnt_reg == CNT_W'(gi))) begin
                    staging_reg[gi] <= WriteData;
                end
            end
            assign staging_flat[32*gi +: 32] = staging_reg[gi];
        end
        for (gi = 0; gi < MAX_FRAMES; gi++) begin : g_strobe
            assign strobe_decode[gi] = (idx_reg == 5'(gi));
        end
    endgenerate

    // Without a checksum word the last data word lands in staging on the same edge
    // the frame is published, so it is taken straight from the bus.
    always_comb begin
        frame_src = staging_flat;
`ifndef CFG_CHECKSUM_EN
        frame_src[FD_W-32 +: 32] = WriteData;
`endif
    end

    always_comb begin
        state_next      = state_reg;
        word_cnt_next   = word_cnt_reg;
        strobe_cnt_next = strobe_cnt_reg;
        col_next        = col_reg;
        idx_next        = idx_reg;
        synced_next     = synced_reg;
        error_next      = error_reg;
        staging_we      = 1'b0;
        frame_done      = 1'b0;
        frame_ok        = 1'b1;
        load_frame      = 1'b0;
`ifdef CFG_CHECKSUM_EN
        checksum_next   = checksum_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (accept && is_sync) begin
                    state_next  = S_HEADER;
                    synced_next = 1'b1;
                    error_next  = 1'b0;
                end
            end
            S_HEADER: begin
                if (accept) begin
                    if (WriteData[0]) begin
                        state_next  = S_IDLE;
                        synced_next = 1'b0;
                    end else if (!is_sync) begin
                        col_next      = WriteData[24 +: COL_ADDR_W];
                        idx_next      = WriteData[23:19];
                        word_cnt_next = '0;
                        state_next    = S_DATA;
`ifdef CFG_CHECKSUM_EN
                        checksum_next = '0;
`endif
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    staging_we    = 1'b1;
                    word_cnt_next = word_cnt_reg + CNT_W'(1);
`ifdef CFG_CHECKSUM_EN
                    checksum_next = checksum_reg ^ WriteData;
                    if (word_cnt_reg == LAST_WORD) state_next = S_CHECK;
`else
                    if (word_cnt_reg == LAST_WORD) frame_done = 1'b1;
`endif
                end
            end
`ifdef CFG_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    frame_done = 1'b1;
                    frame_ok   = (WriteData == checksum_reg);
                end
            end
`endif
            S_STROBE: begin
                strobe_cnt_next = strobe_cnt_reg + SCNT_W'(1);
                if (strobe_cnt_reg == LAST_STROBE) state_next = S_HOLD;
            end
            S_HOLD:   state_next = S_HEADER;
            default:  state_next = S_IDLE;
        endcase

        // A rejected frame (bad index or checksum) skips the strobe but still takes the HOLD cycle.
        if (frame_done) begin
            if (frame_ok && idx_valid) begin
                state_next      = S_STROBE;
                strobe_cnt_next = '0;
                load_frame      = 1'b1;
            end else begin
                state_next = S_HOLD;
                error_next = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg      <= S_IDLE;
            word_cnt_reg   <= '0;
            strobe_cnt_reg <= '0;
            col_reg        <= '0;
            idx_reg        <= '0;
            synced_reg     <= 1'b0;
            error_reg      <= 1'b0;
            frame_data_reg <= '0;
            frame_addr_reg <= '0;
            strobe_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            word_cnt_reg   <= word_cnt_next;
            strobe_cnt_reg <= strobe_cnt_next;
            col_reg        <= col_next;
            idx_reg        <= idx_next;
            synced_reg     <= synced_next;
            error_reg      <= error_next;
            strobe_reg     <= (state_next == S_STROBE) ? strobe_decode : '0;
            if (load_frame) begin
                frame_data_reg <= frame_src;
                frame_addr_reg <= col_reg;
            end
        end
    end

`ifdef CFG_CHECKSUM_EN
    always_ff @(posedge CLK) begin
        if (RESET) checksum_reg <= '0;
        else       checksum_reg <= checksum_next;
    end
`endif

    assign FrameData    = frame_data_reg;
    assign FrameAddress = frame_addr_reg;
    assign FrameStrobe  = strobe_reg;
    assign Synced       = synced_reg;
    assign Error        = error_reg;
endmodule

// File: doc/config_frame_loader.md
Name: config_frame_loader

Overview:
- Upstream stage of the fabric configuration latches (level-sensitive D/E latch cells that hold the switch-matrix mux selects).
- Parses a 32-bit configuration word stream, assembles one frame per column, then drives the frame data and a one-hot frame strobe onto the latch E pins.
- The strobe is pulse-shaped so D is stable before E rises and after E falls.
- Sits between the bitstream source (UART/SPI/host bus front-end) and the tile frame-data/frame-strobe distribution.

Parameters:
- NUM_ROWS, 4, 32-bit data words per frame; FrameData width = 32*NUM_ROWS.
- MAX_FRAMES, 20, frames per column; FrameStrobe width. Legal range 1..32.
- COL_ADDR_W, 5, column address width. Legal range 1..8.
- STROBE_CYCLES, 2, cycles FrameStrobe is held high. Must be ≥1.
- SYNC_WORD, 32'hFAB0_FAB1, stream synchronisation word.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- WriteData  in  32  configuration word.
- WriteStrobe  in  1  word valid; accepted when WriteStrobe && WriteReady.
- WriteReady  out  1  loader can accept a word.
- FrameData  out  32*NUM_ROWS  assembled frame to the latch D pins.
- FrameAddress  out  COL_ADDR_W  target column select.
- FrameStrobe  out  MAX_FRAMES  one-hot latch enable.
- Synced  out  1  loader is inside a sync/desync window.
- Error  out  1  sticky; cleared by RESET or by accepting SYNC_WORD in IDLE.

Behaviour:
- Interface: one clock (CLK); reset is synchronous and active-high (RESET).
- Reset values: WriteReady=1, FrameData=0, FrameAddress=0, FrameStrobe=0, Synced=0, Error=0, state=IDLE, word counter=0.
- States:
  - IDLE:
    - Accepted SYNC_WORD -> HEADER, Synced=1, Error=0.
    - Any other accepted word is discarded.
  - HEADER:
    - Header layout: [31:24] column (low COL_ADDR_W bits used), [23:19] frame index, [0] desync.
    - If desync=1 -> IDLE and Synced=0; other fields ignored.
    - Else if the word equals SYNC_WORD, it is ignored and the state stays HEADER.
    - Else column and index are latched into shadow registers and the state goes to DATA with counter=0.
  - DATA:
    - Data word k (0-based) is written to staging[32k+31:32k]. SYNC_WORD has no special meaning here.
    - When the NUM_ROWS-th word is accepted: with CFG_CHECKSUM_EN -> CHECK, else -> STROBE.
  - STROBE entry:
    - Staging is copied to FrameData and the shadow column to FrameAddress, registered on the same edge as the state change.
    - If index < MAX_FRAMES, FrameStrobe[index]=1 for exactly STROBE_CYCLES cycles.
    - If index ≥ MAX_FRAMES, Error=1, FrameData and FrameAddress are not updated, no strobe is issued, and the state goes straight to HOLD.
  - HOLD: one cycle with FrameStrobe=0, FrameData and FrameAddress unchanged; then -> HEADER.
- WriteReady is 0 in STROBE and HOLD, and 1 in every other state.
- Latency: last data word accepted at edge N -> FrameStrobe high in cycles N+1..N+STROBE_CYCLES -> HOLD at cycle N+STROBE_CYCLES+1 -> WriteReady=1 at N+STROBE_CYCLES+2.
- At most one FrameStrobe bit is ever high.
- FrameData and FrameAddress change only on the edge entering STROBE. They are stable for the entire strobe window and the HOLD cycle.
- Staging writes never disturb FrameData.
- WriteStrobe while WriteReady=0: the word is dropped, with no state change.
- RESET mid-frame: the next edge forces all reset values. FrameStrobe drops immediately and the partial frame is lost.

Optional Feature:
- Macro: CFG_CHECKSUM_EN.
- Defined:
  - After the NUM_ROWS data words, one further accepted word in CHECK state must equal the XOR of all the frame's data words.
  - Match -> STROBE; the strobe appears one accepted word later than without the feature.
  - Mismatch -> Error=1, no FrameData/FrameAddress update, no strobe, -> HOLD -> HEADER.
- Undefined: there is no CHECK state and no checksum word; DATA goes directly to STROBE.

Test Plan:
- Reset, then SYNC_WORD, header 32'h0310_0000 (col 3, frame 2), data 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444 -> FrameAddress=3, FrameData=128'h44444444_33333333_22222222_11111111, FrameStrobe=20'h00004 for 2 cycles, WriteReady=0 for 3 cycles.
- Words 32'hDEADBEEF and 32'h0 before sync -> no output change, Synced=0. Then SYNC_WORD -> Synced=1. Then header 32'h0000_0001 -> Synced=0, state IDLE.
- Header with frame index 25 (32'h00C8_0000) plus 4 data words -> Error=1, FrameStrobe stays 0, FrameData keeps its prior value. Next SYNC_WORD after desync clears Error.
- WriteStrobe held high continuously across two back-to-back frames -> words offered in STROBE/HOLD are dropped. The second frame completes only with re-presented words, and its strobe bit is correct.
- RESET asserted during the first strobe cycle -> FrameStrobe=0 and FrameData=0 next cycle, Synced=0. A fresh frame after reset loads correctly.
- With CFG_CHECKSUM_EN, correct checksum 32'h44444444 for the first scenario's data -> strobe issued. Checksum 32'h0 -> Error=1 and no strobe.
